// File: rtl/picomem_dma_pkg.sv
// picomem_dma_pkg: register offsets, CTRL/STATUS bit positions, engine state
// encoding and a byte-strobe merge helper shared by the DMA engine files.
package picomem_dma_pkg;

   // Register offsets, decoded from cfg_addr[3:2]
   localparam logic [1:0] RegSrc  = 2'd0;
   localparam logic [1:0] RegDst  = 2'd1;
   localparam logic [1:0] RegLen  = 2'd2;
   localparam logic [1:0] RegCtrl = 2'd3;

   // CTRL (write) bit positions
   localparam int unsigned CtrlStartBit = 0;
   localparam int unsigned CtrlClrBit   = 1;

   // STATUS (read) bit positions
   localparam int unsigned StatBusyBit = 0;
   localparam int unsigned StatDoneBit = 1;
   localparam int unsigned StatRemLsb  = 16;

   // Copy engine states
   typedef enum logic [2:0] {
      StIdle = 3'd0,
      StRd   = 3'd1,
      StRgap = 3'd2,
      StWr   = 3'd3,
      StWgap = 3'd4
   } state_e;

   // Replace the bytes of old_val selected by strb with the matching bytes of new_val
   function automatic logic [31:0] apply_strb(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  strb);
      logic [31:0] res;
      res = old_val;
      for (int i = 0; i < 4; i++) begin
         if (strb[i]) res[8*i +: 8] = new_val[8*i +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/picomem_dma_regs.sv
// picomem_dma_regs: responder-side register file for the DMA engine.
// Handles the registered one-cycle cfg_ready handshake, holds SRC/DST/LEN,
// and emits one-cycle start / done_clear pulses to the copy engine.
module picomem_dma_regs
   import picomem_dma_pkg::*;
#(
   parameter int unsigned LEN_W = 16
) (
   input  logic             i_clk,
   input  logic             i_resetn,
   input  logic             i_cfg_valid,
   input  logic [31:0]      i_cfg_addr,
   input  logic [31:0]      i_cfg_wdata,
   input  logic [3:0]       i_cfg_wstrb,
   output logic             o_cfg_ready,
   output logic [31:0]      o_cfg_rdata,
   input  logic             i_busy,
   input  logic             i_done,
   input  logic [LEN_W-1:0] i_remaining,
   output logic             o_start,
   output logic             o_done_clear,
   output logic [31:0]      o_src,
   output logic [31:0]      o_dst,
   output logic [LEN_W-1:0] o_len
);

   logic             r_cfg_ready;
   logic [31:0]      r_cfg_rdata;
   logic             r_start;
   logic             r_done_clear;
   logic [31:0]      r_src;
   logic [31:0]      r_dst;
   logic [LEN_W-1:0] r_len;

   logic             w_accept;
   logic             w_write;
   logic [1:0]       w_sel;
   logic [31:0]      w_status;
   logic [31:0]      w_rdata;
   logic             w_unused_addr;

   // A request is accepted on the edge that raises cfg_ready
   assign w_accept      = i_cfg_valid & ~r_cfg_ready;
   assign w_write       = w_accept & (|i_cfg_wstrb);
   assign w_sel         = i_cfg_addr[3:2];
   assign w_unused_addr = ^{i_cfg_addr[31:4], i_cfg_addr[1:0]};

   // Read-data mux, including the live STATUS word from the engine
   always_comb begin
      w_status                        = '0;
      w_status[StatBusyBit]           = i_busy;
      w_status[StatDoneBit]           = i_done;
      w_status[StatRemLsb +: 16]      = 16'(i_remaining);
      unique case (w_sel)
         RegSrc:  w_rdata = r_src;
         RegDst:  w_rdata = r_dst;
         RegLen:  w_rdata = 32'(r_len);
         RegCtrl: w_rdata = w_status;
         default: w_rdata = '0;
      endcase
   end

   // Handshake, read-data capture, register writes and control pulses
   always_ff @(posedge i_clk or negedge i_resetn) begin
      if (!i_resetn) begin
         r_cfg_ready  <= 1'b0;
         r_cfg_rdata  <= '0;
         r_start      <= 1'b0;
         r_done_clear <= 1'b0;
         r_src        <= '0;
         r_dst        <= '0;
         r_len        <= '0;
      end else begin
         r_cfg_ready  <= w_accept;
         r_cfg_rdata  <= w_accept ? w_rdata : 32'h0;
         r_start      <= w_write & (w_sel == RegCtrl) & i_cfg_wdata[CtrlStartBit] & ~i_busy;
         r_done_clear <= w_write & (w_sel == RegCtrl) & i_cfg_wdata[CtrlClrBit];
         // Address/length registers are frozen while a copy is running
         if (w_write && !i_busy) begin
            unique case (w_sel)
               RegSrc:  r_src <= apply_strb(r_src, i_cfg_wdata, i_cfg_wstrb) & 32'hFFFF_FFFC;
               RegDst:  r_dst <= apply_strb(r_dst, i_cfg_wdata, i_cfg_wstrb) & 32'hFFFF_FFFC;
               RegLen:  r_len <= LEN_W'(apply_strb(32'(r_len), i_cfg_wdata, i_cfg_wstrb));
               default: ;
            endcase
         end
      end
   end

   assign o_cfg_ready  = r_cfg_ready;
   assign o_cfg_rdata  = r_cfg_rdata;
   assign o_start      = r_start;
   assign o_done_clear = r_done_clear;
   assign o_src        = r_src;
   assign o_dst        = r_dst;
   assign o_len        = r_len;

endmodule

// File: rtl/picomem_dma.sv
// picomem_dma: single-channel word-copy DMA engine for the PicoMem bus.
// Copies LEN words from SRC to DST in ascending order, one read then one
// write per word, with an idle cycle after every initiator transaction.
// Optional feature macro: PICOMEM_DMA_IRQ_EN adds a level irq output that
// mirrors the done flag.
module picomem_dma
   import picomem_dma_pkg::*;
#(
   parameter int unsigned LEN_W = 16
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        cfg_valid,
   input  logic [31:0] cfg_addr,
   input  logic [31:0] cfg_wdata,
   input  logic [3:0]  cfg_wstrb,
   output logic        cfg_ready,
   output logic [31:0] cfg_rdata,
   output logic        mem_m_valid,
   output logic [31:0] mem_m_addr,
   output logic [31:0] mem_m_wdata,
   output logic [3:0]  mem_m_wstrb,
   input  logic        mem_m_ready,
   input  logic [31:0] mem_m_rdata
`ifdef PICOMEM_DMA_IRQ_EN
   ,
   output logic        irq
`endif
);

   state_e           r_state;
   logic [31:0]      r_src_ptr;
   logic [31:0]      r_dst_ptr;
   logic [LEN_W-1:0] r_rem;
   logic [31:0]      r_data;
   logic             r_busy;
   logic             r_done;
   logic             r_m_valid;
   logic [31:0]      r_m_addr;
   logic [31:0]      r_m_wdata;
   logic [3:0]       r_m_wstrb;

   logic             w_start;
   logic             w_done_clear;
   logic [31:0]      w_src;
   logic [31:0]      w_dst;
   logic [LEN_W-1:0] w_len;

   picomem_dma_regs #(
      .LEN_W (LEN_W)
   ) u_regs (
      .i_clk        (clk),
      .i_resetn     (resetn),
      .i_cfg_valid  (cfg_valid),
      .i_cfg_addr   (cfg_addr),
      .i_cfg_wdata  (cfg_wdata),
      .i_cfg_wstrb  (cfg_wstrb),
      .o_cfg_ready  (cfg_ready),
      .o_cfg_rdata  (cfg_rdata),
      .i_busy       (r_busy),
      .i_done       (r_done),
      .i_remaining  (r_rem),
      .o_start      (w_start),
      .o_done_clear (w_done_clear),
      .o_src        (w_src),
      .o_dst        (w_dst),
      .o_len        (w_len)
   );

   // Copy engine FSM with registered initiator outputs
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state   <= StIdle;
         r_src_ptr <= '0;
         r_dst_ptr <= '0;
         r_rem     <= '0;
         r_data    <= '0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_m_valid <= 1'b0;
         r_m_addr  <= '0;
         r_m_wdata <= '0;
         r_m_wstrb <= '0;
      end else begin
         if (w_done_clear) r_done <= 1'b0;
         unique case (r_state)
            StIdle: begin
               if (w_start) begin
                  if (w_len != '0) begin
                     r_done    <= 1'b0;
                     r_src_ptr <= w_src;
                     r_dst_ptr <= w_dst;
                     r_rem     <= w_len;
                     r_busy    <= 1'b1;
                     r_m_valid <= 1'b1;
                     r_m_addr  <= w_src;
                     r_m_wstrb <= 4'b0000;
                     r_state   <= StRd;
                  end else begin
                     // Empty transfer completes immediately without bus traffic
                     r_done    <= 1'b1;
                  end
               end
            end
            StRd: begin
               if (mem_m_ready) begin
                  r_data    <= mem_m_rdata;
                  r_m_valid <= 1'b0;
                  r_state   <= StRgap;
               end
            end
            StRgap: begin
               r_m_valid <= 1'b1;
               r_m_addr  <= r_dst_ptr;
               r_m_wdata <= r_data;
               r_m_wstrb <= 4'b1111;
               r_state   <= StWr;
            end
            StWr: begin
               if (mem_m_ready) begin
                  r_src_ptr <= r_src_ptr + 32'd4;
                  r_dst_ptr <= r_dst_ptr + 32'd4;
                  r_rem     <= r_rem - LEN_W'(1);
                  r_m_valid <= 1'b0;
                  r_m_wstrb <= 4'b0000;
                  r_state   <= StWgap;
               end
            end
            StWgap: begin
               if (r_rem == '0) begin
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_state <= StIdle;
               end else begin
                  r_m_valid <= 1'b1;
                  r_m_addr  <= r_src_ptr;
                  r_m_wstrb <= 4'b0000;
                  r_state   <= StRd;
               end
            end
            default: begin
               r_state   <= StIdle;
               r_busy    <= 1'b0;
               r_m_valid <= 1'b0;
            end
         endcase
      end
   end

   assign mem_m_valid = r_m_valid;
   assign mem_m_addr  = r_m_addr;
   assign mem_m_wdata = r_m_wdata;
   assign mem_m_wstrb = r_m_wstrb;

`ifdef PICOMEM_DMA_IRQ_EN
   assign irq = r_done;
`endif

endmodule

// File: doc/picomem_dma.md
# picomem_dma

Single-channel word-copy DMA engine for the PicoMem native bus. It has a PicoMem responder port for configuration and a PicoMem initiator port that issues its own read/write transactions. Firmware programs source, destination and word count, then starts a transfer. The initiator port feeds an extra master input of the system bus arbiter, so the engine can copy SPI-flash contents to SRAM or stream buffers into UART/GPIO without CPU load.

## Interface
Parameters:
- LEN_W, 16, width of the word-count register; the maximum transfer is 2^LEN_W-1 words.

Ports:
- clk  in  1  system clock
- resetn  in  1  reset; asynchronous, active-low
- cfg_valid  in  1  responder request
- cfg_addr  in  32  responder address; only [3:2] decoded
- cfg_wdata  in  32  responder write data
- cfg_wstrb  in  4  responder byte strobes; 0000 means read
- cfg_ready  out  1  responder acknowledge
- cfg_rdata  out  32  responder read data
- mem_m_valid  out  1  initiator request
- mem_m_addr  out  32  initiator address, word aligned
- mem_m_wdata  out  32  initiator write data
- mem_m_wstrb  out  4  initiator strobes: 0000 on reads, 1111 on writes
- mem_m_ready  in  1  initiator acknowledge
- mem_m_rdata  in  32  initiator read data
- irq  out  1  done interrupt; present only with PICOMEM_DMA_IRQ_EN

## Operation
Register map (addr[3:2]):
- 00 SRC: read/write. Bits [1:0] are forced to 0.
- 01 DST: read/write. Bits [1:0] are forced to 0.
- 10 LEN: read/write. Uses [LEN_W-1:0]; upper bits read as 0.
- 11 CTRL/STATUS:
  - Write: bit0=1 starts a transfer; bit1=1 clears done (write-1-to-clear).
  - Read: bit0=busy, bit1=done, [31:16]=remaining words.

Register write rules:
- Byte strobes are honoured on SRC, DST and LEN.
- Writes to SRC, DST and LEN while busy are ignored.
- A start while busy is ignored.
- A start also clears done.

State machine: IDLE -> RD -> RGAP -> WR -> WGAP.
- IDLE: on start with LEN≠0, load the working address counters and remaining count from SRC, DST and LEN, set busy, go to RD.
- IDLE: on start with LEN=0, set done the next cycle; no bus traffic occurs.
- RD: mem_m_valid=1, addr=src_ptr, wstrb=0000. When mem_m_ready=1, latch mem_m_rdata into the data register and go to RGAP.
- RGAP: mem_m_valid=0 for one cycle, then go to WR.
- WR: mem_m_valid=1, addr=dst_ptr, wdata=data register, wstrb=1111. When mem_m_ready=1, add 4 to src_ptr and dst_ptr, decrement remaining, go to WGAP.
- WGAP: mem_m_valid=0 for one cycle. If remaining=0, go to IDLE, clear busy and set done; otherwise go to RD.

Boundary rules:
- Pointer arithmetic is 32-bit modulo; 0xFFFF_FFFC+4 wraps to 0x0000_0000.
- The SRC/DST registers themselves are not modified by a transfer; only the working copies advance.
- Overlapping source and destination ranges are not detected; data is copied in ascending address order.

## Timing
- Reset values:
  - cfg_ready=0, cfg_rdata=0
  - mem_m_valid=0, mem_m_addr=0, mem_m_wdata=0, mem_m_wstrb=0
  - irq=0
  - all registers 0, state IDLE
- Responder port:
  - cfg_ready is registered. It rises the cycle after cfg_valid is sampled with cfg_ready=0, stays high for one cycle, then returns low.
  - cfg_rdata is valid in the same cycle as cfg_ready.
  - A register write takes effect on that same acknowledging edge.
- Initiator port:
  - All initiator outputs are registered.
  - Once mem_m_valid is high, mem_m_valid, addr, wdata and wstrb stay stable until mem_m_ready is sampled high.
  - mem_m_valid is always low for at least one cycle between transactions.
- Latency:
  - The start write acknowledge is followed by RD on the next cycle.
  - With a zero-wait responder, one word takes 4 cycles.
  - busy falls, and done rises, on the edge that leaves WGAP for the last word.
- Reset mid-transfer: mem_m_valid drops immediately (asynchronously), the engine returns to IDLE and the transfer is abandoned.

## Configuration
- PICOMEM_DMA_IRQ_EN defined:
  - irq port exists and equals the done flag (level-sensitive).
  - irq is cleared by a CTRL write with bit1=1, or by a new start.
- PICOMEM_DMA_IRQ_EN undefined: no irq port; firmware polls STATUS.

## Structure
- Package picomem_dma_pkg holds:
  - register offsets (SRC, DST, LEN, CTRL)
  - CTRL/STATUS bit positions
  - state encoding IDLE/RD/RGAP/WR/WGAP
- Sub-module picomem_dma_regs: the responder-side register file and handshake. Its outputs to the core are start, done_clear and the SRC/DST/LEN values.

## Test plan
- Reset: hold resetn=0 -> all outputs 0; STATUS reads 0x0000_0000.
- Basic copy:
  - Stimulus: SRC=0x0000_1000, DST=0x0000_2000, LEN=3, CTRL=1; zero-wait memory holds 0xA0,0xA1,0xA2.
  - Required: reads at 0x1000/0x1004/0x1008 with wstrb 0000; writes at 0x2000/0x2004/0x2008 with wstrb 1111 and matching data; done 12 cycles after start; STATUS=0x0000_0002.
- LEN=0 start -> no mem_m_valid pulse; STATUS done=1 one cycle later.
- Wait states: responder asserts ready 3 cycles after valid -> mem_m_valid/addr/wdata/wstrb stable throughout; each word takes 10 cycles.
- Writes while busy: during a LEN=4 transfer, write SRC=0xDEAD_0000 and CTRL=1 -> SRC unchanged, a single transfer of 4 words; pointer wrap from SRC=0xFFFF_FFFC with LEN=2 -> second read at 0x0000_0000.
- Reset mid-transfer: assert resetn=0 during WR -> mem_m_valid=0 without waiting for a clock edge; after release STATUS=0. With PICOMEM_DMA_IRQ_EN: irq=1 at done; CTRL write of 0x2 -> irq=0.
